// File: rtl/morse_receiver.sv
// Morse line receiver: recovers the 14-bit on/off frame shifted out by the blinker
// and decodes it back to the letter index (S..Z), flagging frames that match no code.
module morse_receiver #(
    parameter int CLKS_PER_SYM = 25000000,
    parameter int CNT_W        = 25
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        line_in,
    output logic [2:0]  letter,
    output logic        letter_valid,
    output logic        frame_error,
    output logic        busy,
    output logic [13:0] frame
);

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, DECODE} state_t;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_SYM / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_SYM - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        bitcnt;
    logic [13:0]       shreg;
    logic              sync_meta;
    logic              s;
    logic              p;
    logic [2:0]        primed;
    logic              rise;
    logic              match_hit;
    logic [2:0]        match_idx;

    function automatic logic [13:0] code_of(input logic [2:0] k);
        case (k)
            3'd0:    code_of = 14'b10101000000000;
            3'd1:    code_of = 14'b11100000000000;
            3'd2:    code_of = 14'b10101110000000;
            3'd3:    code_of = 14'b10101011100000;
            3'd4:    code_of = 14'b10111011100000;
            3'd5:    code_of = 14'b11101010111000;
            3'd6:    code_of = 14'b11101011101110;
            default: code_of = 14'b11101110101000;
        endcase
    endfunction

    // primed[2] marks that p holds a real post-reset sample, so a line that is
    // already high when reset releases does not look like a 0-to-1 transition.
    assign rise = s & ~p & primed[2];

    always_comb begin
        match_hit = 1'b0;
        match_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (shreg == code_of(3'(k))) begin
                match_hit = 1'b1;
                match_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            sync_meta    <= 1'b0;
            s            <= 1'b0;
            p            <= 1'b0;
            primed       <= '0;
            letter       <= '0;
            letter_valid <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
            frame        <= '0;
        end else begin
            sync_meta    <= line_in;
            s            <= sync_meta;
            p            <= s;
            primed       <= {primed[1:0], 1'b1};
            letter_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt   <= HALF_LOAD;
                            state <= ALIGN;
                            busy  <= 1'b1;
                        end
                    end
                    ALIGN: begin
                        if (cnt == '0) begin
                            if (s) begin
                                shreg  <= 14'd1;
                                bitcnt <= 4'd1;
                                cnt    <= FULL_LOAD;
                                state  <= SHIFT;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (cnt == '0) begin
                            shreg  <= {shreg[12:0], s};
                            bitcnt <= bitcnt + 4'd1;
                            cnt    <= FULL_LOAD;
                            if (bitcnt == 4'd13) begin
                                state <= DECODE;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        frame <= shreg;
                        if (match_hit) begin
                            letter       <= match_idx;
                            letter_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        // A frame starting right on the decode cycle is picked up directly.
                        if (rise) begin
                            cnt   <= HALF_LOAD;
                            state <= ALIGN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: table-driven and random frames checked against a
// code-table reference model, plus glitch, freeze and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_morse_receiver;

    localparam int CLKS = 8;
    localparam int LAT  = CLKS * 27 / 2 + 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        line_in = 1'b1;
    logic [2:0]  letter;
    logic        letter_valid;
    logic        frame_error;
    logic        busy;
    logic [13:0] frame;

    morse_receiver #(.CLKS_PER_SYM(CLKS), .CNT_W(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .line_in(line_in),
        .letter(letter),
        .letter_valid(letter_valid),
        .frame_error(frame_error),
        .busy(busy),
        .frame(frame)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic        v;
        logic        e;
        logic [2:0]  l;
        logic [13:0] f;
    } pulse_t;

    typedef struct {
        logic [13:0] bits;
        int          gap;
        logic        exp_v;
        logic        exp_e;
        logic [2:0]  exp_l;
    } vec_t;

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    pulse_t      got_q[$];
    pulse_t      exp_q[$];
    pulse_t      mon_p;
    logic [13:0] codes [8];
    logic [2:0]  model_letter = 3'd0;
    vec_t        vecs [10];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Record every output pulse with its cycle stamp.
    always @(negedge clock) begin
        if (letter_valid || frame_error) begin
            checkOutput("pulse_exclusive", 32'(letter_valid & frame_error), 32'd0);
            mon_p.cyc = cyc;
            mon_p.v   = letter_valid;
            mon_p.e   = frame_error;
            mon_p.l   = letter;
            mon_p.f   = frame;
            got_q.push_back(mon_p);
        end
    end

    // Reference model: exact lookup in the code table; letter persists on errors.
    task automatic modelDecode(input logic [13:0] bits, output logic v, output logic e,
                               output logic [2:0] l);
        v = 1'b0;
        l = model_letter;
        for (int k = 0; k < 8; k++) begin
            if (codes[k] == bits) begin
                v = 1'b1;
                l = 3'(k);
            end
        end
        e = ~v;
    endtask

    task automatic applyStimulus(input logic [13:0] bits, input int gap, input int freeze_bit,
                                 input int freeze_len, input logic ev, input logic ee,
                                 input logic [2:0] el);
        pulse_t x;
        int     start = 0;
        for (int i = 13; i >= 0; i--) begin
            @(posedge clock);
            #1 line_in = bits[i];
            if (i == 13) start = cyc;
            if (13 - i == freeze_bit) begin
                repeat (2) @(posedge clock);
                #1 enable = 1'b0;
                repeat (freeze_len) @(posedge clock);
                #1 enable = 1'b1;
                repeat (CLKS - 3) @(posedge clock);
            end else begin
                repeat (CLKS - 1) @(posedge clock);
            end
        end
        if (gap > 0) begin
            @(posedge clock);
            #1 line_in = 1'b0;
            repeat (gap - 1) @(posedge clock);
        end
        x.cyc = start + LAT + ((freeze_bit >= 0) ? freeze_len : 0);
        x.v   = ev;
        x.e   = ee;
        x.l   = el;
        x.f   = bits;
        exp_q.push_back(x);
        model_letter = el;
    endtask

    task automatic verifyPulses(input string tag);
        pulse_t g;
        pulse_t x;
        int     waited = 0;
        while (got_q.size() < exp_q.size() && waited < 400) begin
            @(posedge clock);
            waited++;
        end
        repeat (CLKS * 2) @(posedge clock);
        checkOutput({tag, "_pulse_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            checkOutput({tag, "_latency"}, 32'(g.cyc), 32'(x.cyc));
            checkOutput({tag, "_valid"},   32'(g.v), 32'(x.v));
            checkOutput({tag, "_error"},   32'(g.e), 32'(x.e));
            checkOutput({tag, "_letter"},  32'(g.l), 32'(x.l));
            checkOutput({tag, "_frame"},   32'(g.f), 32'(x.f));
        end
        got_q.delete();
        exp_q.delete();
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          busy_cnt;
        logic        mv;
        logic        me;
        logic [2:0]  ml;
        logic [13:0] rbits;

        codes[0] = 14'b10101000000000;
        codes[1] = 14'b11100000000000;
        codes[2] = 14'b10101110000000;
        codes[3] = 14'b10101011100000;
        codes[4] = 14'b10111011100000;
        codes[5] = 14'b11101010111000;
        codes[6] = 14'b11101011101110;
        codes[7] = 14'b11101110101000;

        vecs[0] = '{14'b11100000000000, 16, 1'b1, 1'b0, 3'd1};
        for (int i = 0; i < 8; i++)
            vecs[1 + i] = '{codes[i], (i == 7) ? 16 : 0, 1'b1, 1'b0, 3'(i)};
        vecs[9] = '{14'h3FFF, 16, 1'b0, 1'b1, 3'd7};

        // Reset with the line already high: no frame may start at reset exit.
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b1;
        checkOutput("reset_letter", 32'(letter), 32'd0);
        checkOutput("reset_frame", 32'(frame), 32'd0);
        checkOutput("reset_valid", 32'(letter_valid), 32'd0);
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy) busy_cnt++;
        end
        checkOutput("no_start_on_high_line", 32'(busy_cnt), 32'd0);
        #1 line_in = 1'b0;
        repeat (10) @(posedge clock);
        verifyPulses("reset_exit");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].bits, vecs[i].gap, -1, 0, vecs[i].exp_v, vecs[i].exp_e,
                          vecs[i].exp_l);
            if (vecs[i].gap > 0) verifyPulses($sformatf("vec%0d", i));
        end

        // Two-cycle glitch: ALIGN for half a symbol, then back to IDLE silently.
        @(posedge clock);
        #1 line_in = 1'b1;
        repeat (2) @(posedge clock);
        #1 line_in = 1'b0;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy) busy_cnt++;
        end
        checkOutput("glitch_busy_cycles", 32'(busy_cnt), 32'(CLKS / 2));
        verifyPulses("glitch");

        applyStimulus(codes[6], 16, 5, 20, 1'b1, 1'b0, 3'd6);
        verifyPulses("freeze");

        // Reset part-way through code 5 abandons that frame.
        for (int i = 13; i >= 7; i--) begin
            @(posedge clock);
            #1 line_in = codes[5][i];
            repeat (CLKS - 1) @(posedge clock);
        end
        @(posedge clock);
        #1 begin
            reset_n = 1'b0;
            line_in = 1'b0;
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        checkOutput("midreset_letter", 32'(letter), 32'd0);
        checkOutput("midreset_frame", 32'(frame), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_valid", 32'(letter_valid), 32'd0);
        model_letter = 3'd0;
        repeat (30) @(posedge clock);
        verifyPulses("midreset");
        applyStimulus(codes[3], 16, -1, 0, 1'b1, 1'b0, 3'd3);
        verifyPulses("after_reset");

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1)
                rbits = codes[$urandom_range(0, 7)];
            else
                rbits = {1'b1, 13'($urandom)};
            modelDecode(rbits, mv, me, ml);
            applyStimulus(rbits, 16, -1, 0, mv, me, ml);
            verifyPulses($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
